// File: rtl/multicycle_controller.sv
// Multicycle RISC-V style control FSM.
// Sequences fetch / decode / execute / memory / writeback for the
// load, store, R-type, I-type ALU, beq and jal instruction classes.
//
// Optional feature macro: MCC_ILLEGAL_TRAP_EN
//   defined   : unknown opcodes trap into ILLEGAL (held until reset) and
//               an extra output port `illegal` flags that state.
//   undefined : unknown opcodes are treated as NOP (DECODE -> FETCH).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// FETCH    | read instruction at PC, PC <= PC+4 once memory is ready
// DECODE   | read registers, precompute branch target OldPC+imm
// MEMADR   | compute load/store address rs1+imm
// MEMREAD  | load access, wait for memory
// MEMWB    | write loaded data to the register file
// MEMWRITE | store access, wait for memory
// EXECR    | register-register ALU operation
// EXECI    | register-immediate ALU operation
// ALUWB    | write ALU result to the register file
// BEQ      | compare rs1-rs2, take branch on zero
// JAL      | PC <= target, compute return address OldPC+4
// ILLEGAL  | trap on unknown opcode (only reachable with the macro)

module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic [3:0] state
`ifdef MCC_ILLEGAL_TRAP_EN
  ,
  output logic       illegal
`endif
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  state_t     state_q, state_d;
  logic [2:0] alu_dec;
  logic       pc_update;
  logic       branch;
  logic       ir_write_raw;
  logic       mem_write_raw;
  logic       reg_write_raw;

  // State register; reset pulls the FSM back to FETCH immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // ALU operation for R/I-type; only R-type (op[5]=1) may select sub.
  always_comb begin
    alu_dec = ALU_ADD;
    case (funct3)
      3'b000:  alu_dec = (op[5] & funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_dec = ALU_SLT;
      3'b110:  alu_dec = ALU_OR;
      3'b111:  alu_dec = ALU_AND;
      default: alu_dec = ALU_ADD;
    endcase
  end

  // Next-state and Moore output decode.
  always_comb begin
    state_d       = state_q;
    pc_update     = 1'b0;
    branch        = 1'b0;
    ir_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    AdrSrc        = 1'b0;
    ResultSrc     = RES_ALUOUT;
    ALUSrcA       = SRCA_PC;
    ALUSrcB       = SRCB_RS2;
    ALUControl    = ALU_ADD;
    ImmSrc        = IMM_I;

    case (state_q)
      S_FETCH: begin
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        if (mem_ready) begin
          ir_write_raw = 1'b1;
          pc_update    = 1'b1;
          state_d      = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_B;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BEQ:            state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
`ifdef MCC_ILLEGAL_TRAP_EN
          default:           state_d = S_ILLEGAL;
`else
          default:           state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = (op == OP_STORE) ? IMM_S : IMM_I;
        state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) begin
          state_d = S_MEMWB;
        end
      end
      S_MEMWB: begin
        ResultSrc     = RES_DATA;
        reg_write_raw = 1'b1;
        state_d       = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc        = 1'b1;
        mem_write_raw = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
        end
      end
      S_EXECR: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        ALUControl = alu_dec;
        state_d    = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        ImmSrc     = IMM_I;
        ALUControl = alu_dec;
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
        state_d       = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        ALUControl = ALU_SUB;
        branch     = 1'b1;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      S_ILLEGAL: begin
        state_d = S_ILLEGAL;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Strobes are forced low while reset is held so a ready memory cannot
  // load IR/PC during the reset window.
  assign PCWrite  = ~reset & (pc_update | (branch & zero));
  assign IRWrite  = ~reset & ir_write_raw;
  assign MemWrite = ~reset & mem_write_raw;
  assign RegWrite = ~reset & reg_write_raw;
  assign state    = state_q;

`ifdef MCC_ILLEGAL_TRAP_EN
  assign illegal = (state_q == S_ILLEGAL);
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: each stimulus cycle pushes
// its hand-computed expected outputs; a monitor pops and compares them.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state;
`ifdef MCC_ILLEGAL_TRAP_EN
  logic       illegal;
`endif

  multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .ImmSrc     (ImmSrc),
    .RegWrite   (RegWrite),
    .state      (state)
`ifdef MCC_ILLEGAL_TRAP_EN
    ,
    .illegal    (illegal)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, adr, mw, irw;
    logic [1:0] rs, sa, sb;
    logic [2:0] alu;
    logic [1:0] imm;
    logic       rw;
  } exp_t;

  typedef struct {
    string nm;
    exp_t  e;
  } item_t;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  item_t q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  function automatic exp_t mk(input logic [3:0] st, input logic pcw, adr, mw, irw,
                              input logic [1:0] rs, sa, sb, input logic [2:0] alu,
                              input logic [1:0] imm, input logic rw);
    exp_t e;
    e = {st, pcw, adr, mw, irw, rs, sa, sb, alu, imm, rw};
    return e;
  endfunction

  // One clock cycle of stimulus plus the expected output for that cycle.
  task automatic step(input string nm, input logic r, input logic [6:0] o,
                      input logic [2:0] f3, input logic f7, input logic z,
                      input logic mr, input exp_t e);
    item_t it;
    @(posedge clk);
    #1;
    reset     = r;
    op        = o;
    funct3    = f3;
    funct7b5  = f7;
    zero      = z;
    mem_ready = mr;
    it.nm = nm;
    it.e  = e;
    q.push_back(it);
  endtask

  // Monitor: compare DUT outputs mid-cycle against the oldest expectation.
  initial begin
    item_t it;
    exp_t  act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        it  = q.pop_front();
        act = {state, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
               ALUSrcB, ALUControl, ImmSrc, RegWrite};
        n_cmp++;
        if (act !== it.e) begin
          n_bad++;
          $display("FAIL %s: actual=%b required=%b (state %0d vs %0d)",
                   it.nm, act, it.e, act.st, it.e.st);
        end
`ifdef MCC_ILLEGAL_TRAP_EN
        n_cmp++;
        if (illegal !== (it.e.st == 4'd11)) begin
          n_bad++;
          $display("FAIL %s_illegal: actual=%b required=%b", it.nm, illegal,
                   (it.e.st == 4'd11));
        end
`endif
      end
    end
  end

  initial begin
    reset = 1'b1; op = '0; funct3 = '0; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b0;

    // reset: FETCH muxes, strobes held low even with memory ready
    step("rst_hold",  1, 7'd0, 3'd0, 0, 0, 1, mk(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b00,0));
    step("rst_rel",   0, LW,   3'd0, 0, 0, 0, mk(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b00,0));
    step("fetch_wait",0, LW,   3'd0, 0, 0, 0, mk(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b00,0));

    // lw: 0,1,2,3,4
    step("lw_fetch", 0, LW, 3'd2, 0, 0, 1, mk(0,1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b00,0));
    step("lw_dec",   0, LW, 3'd2, 0, 0, 1, mk(1,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b10,0));
    step("lw_adr",   0, LW, 3'd2, 0, 0, 1, mk(2,0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b00,0));
    step("lw_rd",    0, LW, 3'd2, 0, 0, 1, mk(3,0,1,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0));
    step("lw_wb",    0, LW, 3'd2, 0, 0, 1, mk(4,0,0,0,0,2'b01,2'b00,2'b00,3'b000,2'b00,1));

    // sw with two wait cycles in MEMWRITE
    step("sw_fetch", 0, SW, 3'd2, 0, 0, 1, mk(0,1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b00,0));
    step("sw_dec",   0, SW, 3'd2, 0, 0, 0, mk(1,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b10,0));
    step("sw_adr",   0, SW, 3'd2, 0, 0, 0, mk(2,0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b01,0));
    step("sw_wr0",   0, SW, 3'd2, 0, 0, 0, mk(5,0,1,1,0,2'b00,2'b00,2'b00,3'b000,2'b00,0));
    step("sw_wr1",   0, SW, 3'd2, 0, 0, 0, mk(5,0,1,1,0,2'b00,2'b00,2'b00,3'b000,2'b00,0));
    step("sw_wr2",   0, SW, 3'd2, 0, 0, 1, mk(5,0,1,1,0,2'b00,2'b00,2'b00,3'b000,2'b00,0));

    // beq taken / not taken; zero=1 in DECODE must not write PC
    step("beq1_fetch", 0, BR, 3'd0, 0, 1, 1, mk(0,1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b00,0));
    step("beq1_dec",   0, BR, 3'd0, 0, 1, 0, mk(1,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b10,0));
    step("beq1_exec",  0, BR, 3'd0, 0, 1, 0, mk(9,1,0,0,0,2'b00,2'b10,2'b00,3'b001,2'b00,0));
    step("beq0_fetch", 0, BR, 3'd0, 0, 0, 1, mk(0,1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b00,0));
    step("beq0_dec",   0, BR, 3'd0, 0, 0, 0, mk(1,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b10,0));
    step("beq0_exec",  0, BR, 3'd0, 0, 0, 0, mk(9,0,0,0,0,2'b00,2'b10,2'b00,3'b001,2'b00,0));

    // R-type sub
    step("rsub_fetch", 0, RT, 3'b000, 1, 0, 1, mk(0,1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b00,0));
    step("rsub_dec",   0, RT, 3'b000, 1, 0, 0, mk(1,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b10,0));
    step("rsub_exec",  0, RT, 3'b000, 1, 0, 0, mk(6,0,0,0,0,2'b00,2'b10,2'b00,3'b001,2'b00,0));
    step("rsub_wb",    0, RT, 3'b000, 1, 0, 0, mk(8,0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,1));

    // I-type addi with funct7b5=1 stays add
    step("iadd_fetch", 0, IT, 3'b000, 1, 0, 1, mk(0,1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b00,0));
    step("iadd_dec",   0, IT, 3'b000, 1, 0, 0, mk(1,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b10,0));
    step("iadd_exec",  0, IT, 3'b000, 1, 0, 0, mk(7,0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b00,0));
    step("iadd_wb",    0, IT, 3'b000, 1, 0, 0, mk(8,0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,1));

    // R-type or, R-type and, I-type slt
    step("ror_fetch",  0, RT, 3'b110, 0, 0, 1, mk(0,1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b00,0));
    step("ror_dec",    0, RT, 3'b110, 0, 0, 0, mk(1,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b10,0));
    step("ror_exec",   0, RT, 3'b110, 0, 0, 0, mk(6,0,0,0,0,2'b00,2'b10,2'b00,3'b011,2'b00,0));
    step("ror_wb",     0, RT, 3'b110, 0, 0, 0, mk(8,0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,1));
    step("rand_fetch", 0, RT, 3'b111, 0, 0, 1, mk(0,1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b00,0));
    step("rand_dec",   0, RT, 3'b111, 0, 0, 0, mk(1,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b10,0));
    step("rand_exec",  0, RT, 3'b111, 0, 0, 0, mk(6,0,0,0,0,2'b00,2'b10,2'b00,3'b010,2'b00,0));
    step("rand_wb",    0, RT, 3'b111, 0, 0, 0, mk(8,0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,1));
    step("islt_fetch", 0, IT, 3'b010, 0, 0, 1, mk(0,1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b00,0));
    step("islt_dec",   0, IT, 3'b010, 0, 0, 0, mk(1,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b10,0));
    step("islt_exec",  0, IT, 3'b010, 0, 0, 0, mk(7,0,0,0,0,2'b00,2'b10,2'b01,3'b101,2'b00,0));
    step("islt_wb",    0, IT, 3'b010, 0, 0, 0, mk(8,0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,1));

    // jal
    step("jal_fetch", 0, JL, 3'd0, 0, 0, 1, mk(0,1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b00,0));
    step("jal_dec",   0, JL, 3'd0, 0, 0, 0, mk(1,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b10,0));
    step("jal_exec",  0, JL, 3'd0, 0, 0, 0, mk(10,1,0,0,0,2'b00,2'b01,2'b10,3'b000,2'b00,0));
    step("jal_wb",    0, JL, 3'd0, 0, 0, 0, mk(8,0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,1));

    // reset asserted while waiting in MEMREAD
    step("rlw_fetch", 0, LW, 3'd2, 0, 0, 1, mk(0,1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b00,0));
    step("rlw_dec",   0, LW, 3'd2, 0, 0, 0, mk(1,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b10,0));
    step("rlw_adr",   0, LW, 3'd2, 0, 0, 0, mk(2,0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b00,0));
    step("rlw_rd",    0, LW, 3'd2, 0, 0, 0, mk(3,0,1,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0));
    step("rlw_rst",   1, LW, 3'd2, 0, 1, 1, mk(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b00,0));
    step("rlw_rel",   0, LW, 3'd2, 0, 0, 0, mk(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b00,0));

    // unknown opcode
    step("bad_fetch", 0, BAD, 3'd0, 0, 0, 1, mk(0,1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b00,0));
    step("bad_dec",   0, BAD, 3'd0, 0, 0, 0, mk(1,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b10,0));
`ifdef MCC_ILLEGAL_TRAP_EN
    step("bad_trap0", 0, BAD, 3'd0, 0, 1, 1, mk(11,0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0));
    step("bad_trap1", 0, BAD, 3'd0, 0, 1, 1, mk(11,0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0));
    step("bad_rst",   1, BAD, 3'd0, 0, 0, 0, mk(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b00,0));
    step("bad_rel",   0, LW,  3'd0, 0, 0, 0, mk(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b00,0));
`else
    step("bad_nop",   0, BAD, 3'd0, 0, 0, 0, mk(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b00,0));
`endif
    step("post_fetch", 0, LW, 3'd0, 0, 0, 1, mk(0,1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b00,0));

    repeat (3) @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: pending=%0d required=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
